// File: rtl/sm_regdump_pkg.sv
// Shared types and constants for the schoolMIPS register dumper.
// SM_REGDUMP_CHECKSUM_EN widens the state encoding to make room for StCsum.
package sm_regdump_pkg;

`ifdef SM_REGDUMP_CHECKSUM_EN
    typedef enum logic [3:0] {
        StIdle, StHdr, StSetup, StSettle, StCapt, StSend, StNext, StFin, StCsum
    } state_e;
`else
    typedef enum logic [2:0] {
        StIdle, StHdr, StSetup, StSettle, StCapt, StSend, StNext, StFin
    } state_e;
`endif

    localparam logic [7:0]  DefaultHdrByte = 8'hA5;
    localparam int unsigned BytesPerReg    = 5;

endpackage

// File: rtl/sm_regdump_ser.sv
// Per-register serializer: idx byte then the 32-bit shadow MSB first, one byte per advance.
// With SM_REGDUMP_CHECKSUM_EN it also XOR-accumulates every byte it hands out.
module sm_regdump_ser
    import sm_regdump_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [4:0]  idx,
    input  logic [31:0] data,
    input  logic        advance,
    output logic [7:0]  byteOut,
    output logic        last
`ifdef SM_REGDUMP_CHECKSUM_EN
    ,
    input  logic        csumClear,
    output logic [7:0]  csum
`endif
);

    localparam logic [2:0] LastSel = 3'(BytesPerReg - 1);

    logic [31:0] shadow_q, shadow_d;
    logic [2:0]  byteSel_q, byteSel_d;

    assign last = (byteSel_q == LastSel);

    always_comb begin
        shadow_d  = shadow_q;
        byteSel_d = byteSel_q;
        if (load) begin
            shadow_d  = data;
            byteSel_d = '0;
        end else if (advance && !last) begin
            byteSel_d = byteSel_q + 3'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_q  <= '0;
            byteSel_q <= '0;
        end else begin
            shadow_q  <= shadow_d;
            byteSel_q <= byteSel_d;
        end
    end

    // idx comes straight from the FSM; it is held constant while a record is sent.
    always_comb begin
        case (byteSel_q)
            3'd0:    byteOut = {3'b000, idx};
            3'd1:    byteOut = shadow_q[31:24];
            3'd2:    byteOut = shadow_q[23:16];
            3'd3:    byteOut = shadow_q[15:8];
            3'd4:    byteOut = shadow_q[7:0];
            default: byteOut = '0;
        endcase
    end

`ifdef SM_REGDUMP_CHECKSUM_EN
    logic [7:0] csum_q, csum_d;

    always_comb begin
        csum_d = csum_q;
        if (csumClear) begin
            csum_d = '0;
        end else if (advance) begin
            csum_d = csum_q ^ byteOut;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else begin
            csum_q <= csum_d;
        end
    end

    assign csum = csum_q;
`endif

endmodule

// File: rtl/sm_regdump.sv
// Debug-port dump master: walks regAddr over a range and streams header + 5-byte records.
// Define SM_REGDUMP_CHECKSUM_EN to append an XOR checksum byte after the last record.
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int unsigned FIRST_REG = 0,
    parameter int unsigned LAST_REG  = 31,
    parameter logic [7:0]  HDR_BYTE  = DefaultHdrByte,
    parameter int unsigned SETTLE    = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    if (LAST_REG > 31 || FIRST_REG > LAST_REG) begin : gen_range_err
        $error("sm_regdump: need FIRST_REG <= LAST_REG <= 31");
    end
    if (SETTLE == 0 || SETTLE > 7) begin : gen_settle_err
        $error("sm_regdump: SETTLE must be 1..7");
    end

    localparam logic [4:0] FirstIdx   = 5'(FIRST_REG);
    localparam logic [4:0] LastIdx    = 5'(LAST_REG);
    localparam logic [2:0] SettleInit = 3'(SETTLE);

    state_e     state_q, state_d;
    logic [4:0] idx_q, idx_d;
    logic [4:0] regAddr_q, regAddr_d;
    logic [2:0] settleCnt_q, settleCnt_d;

    logic       accept;
    logic       serLast;
    logic [7:0] serByte;

    assign accept  = tx_valid && tx_ready;
    assign regAddr = regAddr_q;

`ifdef SM_REGDUMP_CHECKSUM_EN
    logic [7:0] csum;
`endif

    sm_regdump_ser u_ser (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (state_q == StCapt),
        .idx      (idx_q),
        .data     (regData),
        .advance  (state_q == StSend && accept),
        .byteOut  (serByte),
        .last     (serLast)
`ifdef SM_REGDUMP_CHECKSUM_EN
        ,
        .csumClear(state_q == StHdr),
        .csum     (csum)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= FirstIdx;
            regAddr_q   <= '0;
            settleCnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            regAddr_q   <= regAddr_d;
            settleCnt_q <= settleCnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        regAddr_d   = regAddr_q;
        settleCnt_d = settleCnt_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StHdr;
                    idx_d   = FirstIdx;
                end
            end
            StHdr: begin
                if (accept) state_d = StSetup;
            end
            StSetup: begin
                regAddr_d   = idx_q;
                settleCnt_d = SettleInit;
                state_d     = StSettle;
            end
            StSettle: begin
                settleCnt_d = settleCnt_q - 3'd1;
                if (settleCnt_q == 3'd1) state_d = StCapt;
            end
            StCapt: state_d = StSend;
            StSend: begin
                if (accept && serLast) state_d = StNext;
            end
            StNext: begin
                // Compare before increment so LAST_REG=31 never wraps idx to 0.
                if (idx_q == LastIdx) begin
`ifdef SM_REGDUMP_CHECKSUM_EN
                    state_d = StCsum;
`else
                    state_d = StFin;
`endif
                end else begin
                    idx_d   = idx_q + 5'd1;
                    state_d = StSetup;
                end
            end
`ifdef SM_REGDUMP_CHECKSUM_EN
            StCsum: begin
                if (accept) state_d = StFin;
            end
`endif
            StFin: begin
                regAddr_d = '0;
                state_d   = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy     = (state_q != StIdle) && (state_q != StFin);
        done     = (state_q == StFin);
        tx_valid = 1'b0;
        tx_data  = '0;
        case (state_q)
            StHdr: begin
                tx_valid = 1'b1;
                tx_data  = HDR_BYTE;
            end
            StSend: begin
                tx_valid = 1'b1;
                tx_data  = serByte;
            end
`ifdef SM_REGDUMP_CHECKSUM_EN
            StCsum: begin
                tx_valid = 1'b1;
                tx_data  = csum;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_sm_regdump.sv
// Directed bench for sm_regdump: three instances cover a short range, the full range and SETTLE=3.
module tb_sm_regdump;

    typedef logic [7:0] bq_t[$];

`ifdef SM_REGDUMP_CHECKSUM_EN
    localparam int FinCycle = 21;
`else
    localparam int FinCycle = 20;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    int checks = 0;
    int errors = 0;

    logic        startA, busyA, doneA, txValidA, txReadyA;
    logic [4:0]  regAddrA;
    logic [31:0] regDataA;
    logic [7:0]  txDataA;
    logic [31:0] rfA [32];
    assign regDataA = rfA[regAddrA];

    logic        startB, busyB, doneB, txValidB, txReadyB;
    logic [4:0]  regAddrB;
    logic [31:0] regDataB;
    logic [7:0]  txDataB;
    logic [31:0] rfB [32];
    assign regDataB = rfB[regAddrB];

    logic        startC, busyC, doneC, txValidC, txReadyC;
    logic [4:0]  regAddrC;
    logic [31:0] regDataC;
    logic [7:0]  txDataC;
    logic [31:0] rfC [32];
    assign regDataC = rfC[regAddrC];

    sm_regdump #(.FIRST_REG(2), .LAST_REG(3), .HDR_BYTE(8'hA5), .SETTLE(1)) dutA (
        .clk(clk), .rst_n(rst_n), .start(startA), .busy(busyA), .done(doneA),
        .regAddr(regAddrA), .regData(regDataA), .tx_data(txDataA), .tx_valid(txValidA),
        .tx_ready(txReadyA)
    );

    sm_regdump dutB (
        .clk(clk), .rst_n(rst_n), .start(startB), .busy(busyB), .done(doneB),
        .regAddr(regAddrB), .regData(regDataB), .tx_data(txDataB), .tx_valid(txValidB),
        .tx_ready(txReadyB)
    );

    sm_regdump #(.FIRST_REG(2), .LAST_REG(3), .HDR_BYTE(8'hA5), .SETTLE(3)) dutC (
        .clk(clk), .rst_n(rst_n), .start(startC), .busy(busyC), .done(doneC),
        .regAddr(regAddrC), .regData(regDataC), .tx_data(txDataC), .tx_valid(txValidC),
        .tx_ready(txReadyC)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] payloadXor(input bq_t q);
        logic [7:0] x = 8'h00;
        for (int i = 1; i < q.size(); i++) x ^= q[i];
        return x;
    endfunction

    function automatic bq_t buildFrame(input int first, input int last, input logic [31:0] rf [32]);
        bq_t q;
        q.push_back(8'hA5);
        for (int i = first; i <= last; i++) begin
            q.push_back(8'(i));
            for (int k = 3; k >= 0; k--) q.push_back(rf[i][8*k +: 8]);
        end
`ifdef SM_REGDUMP_CHECKSUM_EN
        q.push_back(payloadXor(q));
`endif
        return q;
    endfunction

    task automatic compareFrame(input string tag, input bq_t got, input bq_t exp);
        check({tag, "_len"}, 32'(got.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(exp[i]));
    endtask

    // Byte capture, done counting and stall-stability checks, all sampled on the falling edge.
    bq_t        qA, qB, qC;
    int         doneCntA = 0, doneCntB = 0, doneCntC = 0;
    logic       stallA = 1'b0;
    logic [7:0] stallDataA = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                stallA = 1'b0;
            end else begin
                if (stallA) begin
                    check("hold_valid", 32'(txValidA), 32'd1);
                    check("hold_data", 32'(txDataA), 32'(stallDataA));
                end
                stallA     = txValidA && !txReadyA;
                stallDataA = txDataA;
                if (txValidA && txReadyA) qA.push_back(txDataA);
                if (txValidB && txReadyB) qB.push_back(txDataB);
                if (txValidC && txReadyC) qC.push_back(txDataC);
                if (doneA) doneCntA++;
                if (doneB) doneCntB++;
                if (doneC) doneCntC++;
            end
        end
    end

    bq_t  expA, expB, expC;
    int   doneAt, n;
    logic got, lastBusy;

    initial begin
        rst_n  = 1'b0;
        startA = 1'b0; startB = 1'b0; startC = 1'b0;
        txReadyA = 1'b0; txReadyB = 1'b0; txReadyC = 1'b0;
        for (int i = 0; i < 32; i++) begin
            rfA[i] = 32'h0;
            rfC[i] = 32'h0;
            rfB[i] = (i == 0) ? 32'h0 : {8'(i), 8'(i) ^ 8'hFF, 8'h5A, 8'(i * 3)};
        end
        rfA[2] = 32'h12345678; rfA[3] = 32'hDEADBEEF;
        rfC[2] = 32'hCAFE0102; rfC[3] = 32'h0BADF00D;
        expA = buildFrame(2, 3, rfA);
        expB = buildFrame(0, 31, rfB);
        expC = buildFrame(2, 3, rfC);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy", 32'(busyA), 32'd0);
        check("rst_done", 32'(doneA), 32'd0);
        check("rst_valid", 32'(txValidA), 32'd0);
        check("rst_data", 32'(txDataA), 32'd0);
        check("rst_regaddr", 32'(regAddrA), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;

        // Short range, ready tied high; start re-pulsed during FIN must be ignored.
        txReadyA = 1'b1; qA.delete(); doneCntA = 0; doneAt = -1;
        @(posedge clk); #1 startA = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1 startA = (c == FinCycle);
            @(negedge clk);
            if (c == 1) begin
                check("hdr_valid_n1", 32'(txValidA), 32'd1);
                check("hdr_data_n1", 32'(txDataA), 32'hA5);
            end
            if (doneA && doneAt < 0) begin
                doneAt = c;
                check("busy_at_done", 32'(busyA), 32'd0);
            end
            if (doneAt > 0 && c == doneAt + 1) check("busy_after_done", 32'(busyA), 32'd0);
        end
        check("done_cycle", 32'(doneAt), 32'(FinCycle));
        check("done_once", 32'(doneCntA), 32'd1);
        compareFrame("short", qA, expA);
`ifdef SM_REGDUMP_CHECKSUM_EN
        check("csum_byte", 32'(qA[qA.size() - 1]), 32'(payloadXor(qA[0:qA.size() - 2])));
`endif

        // Random back-pressure with extra start pulses while busy.
        qA.delete(); doneCntA = 0; got = 1'b0; lastBusy = 1'b0;
        @(posedge clk); #1 startA = 1'b1; txReadyA = 1'b0;
        for (int c = 1; c <= 800 && !got; c++) begin
            @(posedge clk); #1;
            startA   = lastBusy && (c == 3 || c == 15 || c == 30);
            txReadyA = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            lastBusy = busyA;
            if (doneA) got = 1'b1;
        end
        @(posedge clk); #1 startA = 1'b0;
        check("rand_done_seen", 32'(got), 32'd1);
        repeat (20) @(posedge clk);
        #1;
        check("rand_done_once", 32'(doneCntA), 32'd1);
        compareFrame("rand", qA, expA);

        // Reset after 7 bytes, then a clean restart.
        txReadyA = 1'b1; qA.delete(); doneCntA = 0; got = 1'b0;
        @(posedge clk); #1 startA = 1'b1;
        @(posedge clk); #1 startA = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk); #1;
            if (qA.size() >= 7) got = 1'b1;
        end
        check("abort_reach7", 32'(got), 32'd1);
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk);
        check("abort_busy", 32'(busyA), 32'd0);
        check("abort_done", 32'(doneA), 32'd0);
        check("abort_valid", 32'(txValidA), 32'd0);
        check("abort_data", 32'(txDataA), 32'd0);
        check("abort_regaddr", 32'(regAddrA), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_done", 32'(doneCntA), 32'd0);
        qA.delete(); got = 1'b0;
        @(posedge clk); #1 startA = 1'b1;
        @(posedge clk); #1 startA = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (doneA) got = 1'b1;
        end
        check("restart_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        compareFrame("restart", qA, expA);

        // Full range: PC + $1..$31.
        txReadyB = 1'b1; qB.delete(); got = 1'b0;
        @(posedge clk); #1 startB = 1'b1;
        @(posedge clk); #1 startB = 1'b0;
        for (int c = 0; c < 600 && !got; c++) begin
            @(negedge clk);
            if (doneB) got = 1'b1;
        end
        check("full_done", 32'(got), 32'd1);
        @(negedge clk);
        check("full_regaddr_idle", 32'(regAddrB), 32'd0);
        check("full_busy_idle", 32'(busyB), 32'd0);
        check("full_done_once", 32'(doneCntB), 32'd1);
        compareFrame("full", qB, expB);

        // SETTLE=3: regAddr held through 3 settle cycles plus capture; late data change ignored.
        txReadyC = 1'b1; qC.delete(); got = 1'b0; n = 0;
        @(posedge clk); #1 startC = 1'b1;
        @(posedge clk); #1 startC = 1'b0;
        for (int c = 0; c < 40 && !got; c++) begin
            @(negedge clk);
            if (txValidC && regAddrC == 5'd2) begin
                got = 1'b1;
                rfC[2] = 32'hFFFF0000;
            end else if (regAddrC == 5'd2) begin
                n++;
            end
        end
        check("settle_seen", 32'(got), 32'd1);
        check("settle_cycles", 32'(n), 32'd4);
        got = 1'b0;
        for (int c = 0; c < 60 && !got; c++) begin
            @(negedge clk);
            if (doneC) got = 1'b1;
        end
        check("settle_done", 32'(got), 32'd1);
        @(posedge clk); #1;
        compareFrame("settle", qC, expC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
